grid_io_tile_cfgchk: RTL
========================

// Module: grid_io_tile_cfgchk
// PURPOSE
//  Parametrised I/O grid tile: NUM_IO embedded SoC pad subtiles behind one configuration chain.
//  Adds a shadow configuration chain with shift-enable, bit counting and an even-parity check.
//  Decoded pad configuration becomes active only after a complete, parity-clean load.
//  Sits on the FPGA fabric perimeter (any side), between the routing channel and the SoC pad ring.
// PARAMETERS
//  NUM_IO   9   number of I/O subtiles (>=1)
//  CHAIN_L  2*NUM_IO+1   derived localparam: 2 cfg bits per IO + 1 parity bit
//  CNT_W    $clog2(CHAIN_L+1)   derived localparam: bit-counter width
// PORTS
//  prog_clk                          in   1        configuration clock (only clock)
//  pReset                            in   1        async, active-high reset
//  IO_ISOL_N                         in   1        global isolation, active-low
//  ccff_en                           in   1        chain shift enable
//  ccff_head                         in   1        serial config in
//  ccff_tail                         out  1        serial config out = chain[CHAIN_L-1]
//  gfpga_pad_EMBEDDED_IO_HD_SOC_IN   in   NUM_IO   pad -> fabric data
//  gfpga_pad_EMBEDDED_IO_HD_SOC_OUT  out  NUM_IO   fabric -> pad data
//  gfpga_pad_EMBEDDED_IO_HD_SOC_DIR  out  NUM_IO   1 = pad is input
//  io_outpad                         in   NUM_IO   fabric output pins
//  io_inpad_upper                    out  NUM_IO   fabric input pins
//  io_inpad_lower                    out  NUM_IO   copy of io_inpad_upper
//  cfg_done                          out  1        active config valid (state READY)
//  cfg_error                         out  1        last load bad (state ERROR)
// BEHAVIOUR
//  Interface: one clock, prog_clk; pReset is asynchronous, active-high.
//  - Chain: CHAIN_L flops. On posedge prog_clk with ccff_en=1: chain[0]<=ccff_head, chain[k]<=chain[k-1].
//  - Chain holds when ccff_en=0.
//  - Bit map after load: chain[2i]=MODE_i (1=input), chain[2i+1]=INV_i (invert inbound data), chain[CHAIN_L-1]=parity.
//  - Parity OK: XOR of all CHAIN_L chain bits == 0.
//  - Counter cnt: cleared on entering LOADING; +1 per shifted bit; saturates at CHAIN_L+1 (overshift flag).
//  - FSM states UNCFG, LOADING, READY, ERROR:
//    UNCFG/READY/ERROR --ccff_en=1--> LOADING. On that first cycle, cnt<=1 and the bit shifts.
//    LOADING, ccff_en=1: stay and count.
//    LOADING, ccff_en=0: if cnt==CHAIN_L and parity OK -> READY, else -> ERROR.
//    Decision is registered one cycle after ccff_en falls.
//  - Active regs act_mode/act_inv [NUM_IO]: load from chain only on the LOADING->READY edge.
//    Hold otherwise.
//    ERROR and LOADING clear them to 0 (safe: all outputs, no inbound).
//  - en = (state==READY) & IO_ISOL_N, combinational. For each i:
//    SOC_DIR[i] = en ? act_mode[i] : 1
//    SOC_OUT[i] = en & ~act_mode[i] & io_outpad[i]
//    io_inpad_upper[i] = en & act_mode[i] & (SOC_IN[i] ^ act_inv[i]); io_inpad_lower[i] = io_inpad_upper[i]
//  - cfg_done = (state==READY); cfg_error = (state==ERROR). Both are registered state decodes.
//  - Reset (async, any time, including mid-load): chain=0, cnt=0, act_*=0, state=UNCFG.
//    While pReset is high and after it: SOC_DIR=all 1, SOC_OUT=0, io_inpad_*=0, cfg_done=0, cfg_error=0, ccff_tail=0.
//  - Reload while READY: outputs drop to safe state the cycle after ccff_en rises.
//    Old config is not retained.
//  - IO_ISOL_N=0 forces the safe state combinationally in any state. It does not alter the FSM or the chain.
//  - ccff_tail follows the shadow chain, so downstream tiles chain normally; ccff_tail is not gated by the FSM.
// TESTING
//  1. Reset, NUM_IO=9: drive no shifts -> SOC_DIR=9'h1FF, SOC_OUT=0, inpad=0, cfg_done=0, cfg_error=0.
//  2. Load 19 bits: all IO output, INV=0, parity 0; drop ccff_en; io_outpad=9'h155 ->
//     cfg_done=1 one cycle later, SOC_DIR=0, SOC_OUT=9'h155.
//  3. Load 19 bits: IO0 input, INV0=1, parity bit=0 (even); SOC_IN[0]=0 ->
//     io_inpad_upper[0]=io_inpad_lower[0]=1, SOC_DIR[0]=1.
//  4. Load 18 bits or 20 bits, or 19 bits with a flipped parity bit ->
//     cfg_error=1, cfg_done=0, all outputs in the safe state.
//  5. From READY, pulse IO_ISOL_N=0 -> safe state in the same cycle, cfg_done stays 1.
//     Then assert pReset mid-load (cnt=7) -> UNCFG, chain=0, ccff_tail=0.
//  6. Chain pass-through: shift 19+5 bits with ccff_en=1 ->
//     ccff_tail reproduces ccff_head delayed by exactly 19 shifting cycles.

Source files
------------

// File: rtl/grid_io_tile_cfgchk.sv
// I/O grid tile: NUM_IO SoC pad subtiles behind a parity-checked shadow config chain.
// Pad configuration goes live only after a complete, parity-clean load.
module grid_io_tile_cfgchk #(
   parameter int NUM_IO = 9
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              IO_ISOL_N,
   input  logic              ccff_en,
   input  logic              ccff_head,
   output logic              ccff_tail,
   input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
   input  logic [NUM_IO-1:0] io_outpad,
   output logic [NUM_IO-1:0] io_inpad_upper,
   output logic [NUM_IO-1:0] io_inpad_lower,
   output logic              cfg_done,
   output logic              cfg_error
);

   localparam int CHAIN_L = 2*NUM_IO + 1;
   localparam int CNT_W   = $clog2(CHAIN_L + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_L);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_L + 1);

   typedef enum logic [1:0] {
      UNCFG   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2,
      ERROR   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CHAIN_L-1:0]  r_chain;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_IO-1:0]   r_act_mode;
   logic [NUM_IO-1:0]   r_act_inv;
   logic [NUM_IO-1:0]   w_chain_mode;
   logic [NUM_IO-1:0]   w_chain_inv;
   logic [NUM_IO-1:0]   w_en;
   logic                w_parity_ok;

   assign w_parity_ok = ~(^r_chain);
   assign ccff_tail   = r_chain[CHAIN_L-1];

   always_comb begin
      w_chain_mode = '0;
      w_chain_inv  = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         w_chain_mode[i] = r_chain[2*i];
         w_chain_inv[i]  = r_chain[2*i+1];
      end
   end

   // Shadow chain shifts independently of the FSM so downstream tiles chain normally
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_chain <= '0;
      end else if (ccff_en) begin
         r_chain <= {r_chain[CHAIN_L-2:0], ccff_head};
      end
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_state <= UNCFG;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         UNCFG, READY, ERROR: begin
            if (ccff_en) w_next = LOADING;
         end
         LOADING: begin
            if (!ccff_en) begin
               if (r_cnt == CNT_FULL && w_parity_ok) w_next = READY;
               else                                  w_next = ERROR;
            end
         end
         default: w_next = UNCFG;
      endcase
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_cnt <= '0;
      end else if (ccff_en) begin
         if (r_state != LOADING)   r_cnt <= CNT_W'(1);
         else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_act_mode <= '0;
         r_act_inv  <= '0;
      end else if (r_state == LOADING && w_next == READY) begin
         r_act_mode <= w_chain_mode;
         r_act_inv  <= w_chain_inv;
      end else if (w_next == LOADING || w_next == ERROR) begin
         r_act_mode <= '0;
         r_act_inv  <= '0;
      end
   end

   always_comb begin
      cfg_done  = (r_state == READY);
      cfg_error = (r_state == ERROR);
   end

   assign w_en = {NUM_IO{(r_state == READY) & IO_ISOL_N}};

   assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = ~w_en | r_act_mode;
   assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = w_en & ~r_act_mode & io_outpad;
   assign io_inpad_upper = w_en & r_act_mode &
                           (gfpga_pad_EMBEDDED_IO_HD_SOC_IN ^ r_act_inv);
   assign io_inpad_lower = io_inpad_upper;

endmodule
